// File: rtl/pulse_filter_nch.sv
// Multi-channel pulse filter: per-channel synchronizer, qualification FSM with a shared
// programmable length/mode, registered rising-edge strobes and a saturating glitch counter.
module pulse_filter_nch #(
    parameter int CH       = 32,
    parameter int CNT_W    = 16,
    parameter int SYNC_STG = 2
) (
    input  logic             clk_20m,
    input  logic             rst,
    input  logic [CH-1:0]    pulse_in,
    input  logic [CNT_W-1:0] filter_cfg,
    input  logic [1:0]       mode_cfg,
    input  logic             cfg_load,
    input  logic             glitch_clr,
    output logic [CH-1:0]    pulse_out,
    output logic [CH-1:0]    rise_stb,
    output logic [15:0]      glitch_cnt
);

    localparam logic [1:0]       MODE_BYP  = 2'b00;
    localparam logic [1:0]       MODE_SYM  = 2'b01;
    localparam logic [1:0]       MODE_RISE = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      GCNT_MAX  = 16'hFFFF;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    // Stored as N-1 so a requested length of 0 folds onto 1 and the compare stays simple.
    function automatic logic [CNT_W-1:0] len_to_last(input logic [CNT_W-1:0] n);
        if (n == CNT_ZERO) begin
            return CNT_ZERO;
        end else begin
            return n - CNT_ONE;
        end
    endfunction

    logic [CNT_W-1:0] len_m1_r;
    logic [1:0]       mode_r;
    logic [CH-1:0]    glitch_vec_s;
    logic             any_glitch_s;
    logic [15:0]      glitch_cnt_r;

    // Active configuration shadow registers
    always_ff @(posedge clk_20m or posedge rst) begin
        if (rst) begin
            len_m1_r <= CNT_ZERO;
            mode_r   <= MODE_SYM;
        end else if (cfg_load) begin
            len_m1_r <= len_to_last(filter_cfg);
            mode_r   <= mode_cfg;
        end else begin
            len_m1_r <= len_m1_r;
            mode_r   <= mode_r;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [SYNC_STG-1:0] sync_r;
        logic                samp_s;
        logic                diff_s;
        state_t              state_r;
        state_t              state_nxt_s;
        logic [CNT_W-1:0]    cnt_r;
        logic [CNT_W-1:0]    cnt_nxt_s;
        logic                pout_r;
        logic                pout_nxt_s;
        logic                pout_d_r;
        logic                rise_r;
        logic                glitch_s;

        assign samp_s = sync_r[SYNC_STG-1];
        assign diff_s = samp_s ^ pout_r;

        // Input synchronizer chain
        always_ff @(posedge clk_20m or posedge rst) begin
            if (rst) begin
                sync_r <= {SYNC_STG{1'b0}};
            end else begin
                sync_r <= {sync_r[SYNC_STG-2:0], pulse_in[gi]};
            end
        end

        // Qualification next-state: cfg_load parks the channel, bypass follows the sample,
        // rise-only drops immediately, otherwise a difference must persist len_m1_r+1 samples.
        always_comb begin
            state_nxt_s = ST_STABLE;
            cnt_nxt_s   = CNT_ZERO;
            pout_nxt_s  = pout_r;
            glitch_s    = 1'b0;
            if (cfg_load) begin
                pout_nxt_s = pout_r;
            end else if (mode_r == MODE_BYP) begin
                pout_nxt_s = samp_s;
            end else if ((mode_r == MODE_RISE) && pout_r && !samp_s) begin
                pout_nxt_s = 1'b0;
            end else if (diff_s) begin
                if (cnt_r >= len_m1_r) begin
                    pout_nxt_s = samp_s;
                end else begin
                    state_nxt_s = ST_QUALIFY;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end else begin
                glitch_s = (state_r == ST_QUALIFY);
            end
        end

        // Channel state, counter, filtered level and edge-detect registers
        always_ff @(posedge clk_20m or posedge rst) begin
            if (rst) begin
                state_r  <= ST_STABLE;
                cnt_r    <= CNT_ZERO;
                pout_r   <= 1'b0;
                pout_d_r <= 1'b0;
                rise_r   <= 1'b0;
            end else begin
                state_r  <= state_nxt_s;
                cnt_r    <= cnt_nxt_s;
                pout_r   <= pout_nxt_s;
                pout_d_r <= pout_r;
                rise_r   <= pout_r & ~pout_d_r;
            end
        end

        assign pulse_out[gi]    = pout_r;
        assign rise_stb[gi]     = rise_r;
        assign glitch_vec_s[gi] = glitch_s;
    end

    assign any_glitch_s = |glitch_vec_s;

    // Saturating glitch counter; clear wins over a coincident glitch
    always_ff @(posedge clk_20m or posedge rst) begin
        if (rst) begin
            glitch_cnt_r <= 16'h0000;
        end else if (glitch_clr) begin
            glitch_cnt_r <= 16'h0000;
        end else if (any_glitch_s && (glitch_cnt_r != GCNT_MAX)) begin
            glitch_cnt_r <= glitch_cnt_r + 16'h0001;
        end else begin
            glitch_cnt_r <= glitch_cnt_r;
        end
    end

    assign glitch_cnt = glitch_cnt_r;

endmodule

// File: tb/tb_pulse_filter_nch.sv
// Directed bench for pulse_filter_nch: a level/latency vector table plus hand-timed
// sequences for qualification, glitches, saturation, reconfiguration and reset.
module tb_pulse_filter_nch;
    localparam int CH       = 32;
    localparam int CNT_W    = 16;
    localparam int SYNC_STG = 2;

    logic             clk_20m = 1'b0;
    logic             rst;
    logic [CH-1:0]    pulse_in;
    logic [CNT_W-1:0] filter_cfg;
    logic [1:0]       mode_cfg;
    logic             cfg_load;
    logic             glitch_clr;
    logic [CH-1:0]    pulse_out;
    logic [CH-1:0]    rise_stb;
    logic [15:0]      glitch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pin;
        logic [31:0] exp_out;
        logic [31:0] exp_rise;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] prev_out;

    always #25 clk_20m = ~clk_20m;

    pulse_filter_nch #(.CH(CH), .CNT_W(CNT_W), .SYNC_STG(SYNC_STG)) dut (
        .clk_20m    (clk_20m),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .filter_cfg (filter_cfg),
        .mode_cfg   (mode_cfg),
        .cfg_load   (cfg_load),
        .glitch_clr (glitch_clr),
        .pulse_out  (pulse_out),
        .rise_stb   (rise_stb),
        .glitch_cnt (glitch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_20m);
        #1;
    endtask

    task automatic load(input logic [15:0] n, input logic [1:0] m);
        filter_cfg = n;
        mode_cfg   = m;
        cfg_load   = 1'b1;
        tick(1);
        cfg_load   = 1'b0;
        filter_cfg = 16'h0007;
        mode_cfg   = 2'b00;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        vecs[1] = '{32'hA5A5_00F0, 32'hA5A5_00F0, 32'hA5A5_00F0};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5A5A_FF0F};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
        vecs[5] = '{32'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h7FFF_FFFE};

        rst        = 1'b1;
        pulse_in   = 32'hFFFF_FFFF;
        filter_cfg = 16'h0000;
        mode_cfg   = 2'b00;
        cfg_load   = 1'b0;
        glitch_clr = 1'b0;
        tick(3);
        chk("rst_out", pulse_out, 32'h0);
        chk("rst_rise", rise_stb, 32'h0);
        chk("rst_gcnt", {16'h0, glitch_cnt}, 32'h0);
        pulse_in = 32'h0;
        rst      = 1'b0;
        tick(2);

        // Default N=1 mode 01: three-clock latency, registered rise strobe
        prev_out = 32'h0;
        for (int i = 0; i < 6; i++) begin
            pulse_in = vecs[i].pin;
            tick(2);
            chk("tbl_hold", pulse_out, prev_out);
            tick(1);
            chk("tbl_out", pulse_out, vecs[i].exp_out);
            tick(1);
            chk("tbl_rise", rise_stb, vecs[i].exp_rise);
            tick(1);
            chk("tbl_rise_off", rise_stb, 32'h0);
            prev_out = vecs[i].exp_out;
        end
        chk("tbl_gcnt", {16'h0, glitch_cnt}, 32'h0);
        pulse_in = 32'h0;
        tick(4);
        chk("idle_out", pulse_out, 32'h0);

        // N=5 mode 01: clean edge on ch3 appears 7 clocks later
        load(16'd5, 2'b01);
        pulse_in = 32'h8;
        tick(6);
        chk("n5_early", pulse_out, 32'h0);
        tick(1);
        chk("n5_rise", pulse_out, 32'h8);
        tick(1);
        chk("n5_stb", rise_stb, 32'h8);
        tick(1);
        chk("n5_stb_off", rise_stb, 32'h0);
        chk("n5_gcnt", {16'h0, glitch_cnt}, 32'h0);
        pulse_in = 32'h0;
        tick(8);
        chk("n5_fall", pulse_out, 32'h0);

        // 4-clock pulses are glitches; two channels in one cycle count once
        pulse_in = 32'h1;
        tick(4);
        pulse_in = 32'h0;
        tick(4);
        chk("gl1_out", pulse_out, 32'h0);
        chk("gl1_cnt", {16'h0, glitch_cnt}, 32'h1);
        pulse_in = 32'h81;
        tick(4);
        pulse_in = 32'h0;
        tick(4);
        chk("gl2_out", pulse_out, 32'h0);
        chk("gl2_cnt", {16'h0, glitch_cnt}, 32'h2);

        // 5-clock pulse on ch1 just qualifies
        pulse_in = 32'h2;
        tick(5);
        pulse_in = 32'h0;
        tick(1);
        chk("p5_early", pulse_out, 32'h0);
        tick(1);
        chk("p5_rise", pulse_out, 32'h2);
        tick(1);
        chk("p5_stb", rise_stb, 32'h2);
        tick(3);
        chk("p5_hold", pulse_out, 32'h2);
        tick(1);
        chk("p5_fall", pulse_out, 32'h0);
        chk("p5_gcnt", {16'h0, glitch_cnt}, 32'h2);

        // Reload N=10 -> N=3 at cnt=6: counter restarts, no glitch counted
        load(16'd10, 2'b01);
        pulse_in   = 32'h4;
        tick(8);
        filter_cfg = 16'd3;
        mode_cfg   = 2'b01;
        cfg_load   = 1'b1;
        tick(1);
        cfg_load   = 1'b0;
        chk("rl_held", pulse_out, 32'h0);
        tick(2);
        chk("rl_early", pulse_out, 32'h0);
        tick(1);
        chk("rl_rise", pulse_out, 32'h4);
        chk("rl_gcnt", {16'h0, glitch_cnt}, 32'h2);
        pulse_in = 32'h0;
        tick(8);
        chk("rl_fall", pulse_out, 32'h0);

        // Mode 10, N=100: slow rise, three-clock fall
        load(16'd100, 2'b10);
        pulse_in = 32'h2;
        tick(101);
        chk("m10_early", pulse_out, 32'h0);
        tick(1);
        chk("m10_rise", pulse_out, 32'h2);
        pulse_in = 32'h0;
        tick(2);
        chk("m10_hold", pulse_out, 32'h2);
        tick(1);
        chk("m10_fall", pulse_out, 32'h0);

        // Mode 00: everything follows with three clocks of delay, glitches included
        load(16'd0, 2'b00);
        pulse_in = 32'h1234_5678;
        tick(2);
        chk("byp_hold", pulse_out, 32'h0);
        tick(1);
        chk("byp_a", pulse_out, 32'h1234_5678);
        pulse_in = 32'hEDCB_A987;
        tick(2);
        chk("byp_hold2", pulse_out, 32'h1234_5678);
        tick(1);
        chk("byp_b", pulse_out, 32'hEDCB_A987);
        pulse_in = 32'h0;
        tick(4);
        pulse_in = 32'h20;
        tick(1);
        pulse_in = 32'h0;
        tick(2);
        chk("byp_pulse", pulse_out, 32'h20);
        tick(1);
        chk("byp_pulse_end", pulse_out, 32'h0);
        chk("byp_gcnt", {16'h0, glitch_cnt}, 32'h2);

        // N=0 behaves as N=1
        load(16'd0, 2'b01);
        pulse_in = 32'h1;
        tick(2);
        chk("n0_early", pulse_out, 32'h0);
        tick(1);
        chk("n0_rise", pulse_out, 32'h1);
        pulse_in = 32'h0;
        tick(4);

        // Saturation: anti-phase toggling on ch0/ch1 gives one glitch per cycle
        load(16'd2, 2'b01);
        for (int i = 0; i < 65600; i++) begin
            pulse_in = (i % 2 == 0) ? 32'h1 : 32'h2;
            tick(1);
        end
        pulse_in = 32'h0;
        tick(6);
        chk("sat_cnt", {16'h0, glitch_cnt}, 32'h0000_FFFF);
        chk("sat_out", pulse_out, 32'h0);
        pulse_in = 32'h1;
        tick(1);
        pulse_in = 32'h0;
        tick(6);
        chk("sat_hold", {16'h0, glitch_cnt}, 32'h0000_FFFF);
        pulse_in   = 32'h1;
        tick(1);
        pulse_in   = 32'h0;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        chk("clr_prio", {16'h0, glitch_cnt}, 32'h0);
        tick(3);
        chk("clr_after", {16'h0, glitch_cnt}, 32'h0);
        pulse_in = 32'h1;
        tick(1);
        pulse_in = 32'h0;
        tick(4);
        chk("gl_post_clr", {16'h0, glitch_cnt}, 32'h1);

        // Async reset at cnt=8 of N=10, then defaults N=1 mode 01
        load(16'd10, 2'b01);
        pulse_in = 32'h10;
        tick(12);
        chk("ar_high", pulse_out, 32'h10);
        pulse_in = 32'h0;
        tick(10);
        chk("ar_pre", pulse_out, 32'h10);
        #10;
        rst = 1'b1;
        #2;
        chk("ar_out", pulse_out, 32'h0);
        chk("ar_gcnt", {16'h0, glitch_cnt}, 32'h0);
        tick(1);
        rst = 1'b0;
        pulse_in = 32'h10;
        tick(2);
        chk("ar_def_early", pulse_out, 32'h0);
        tick(1);
        chk("ar_def_rise", pulse_out, 32'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_filter_nch.md
PULSE_FILTER_NCH -- requirements
Module: pulse_filter_nch

Interface
REQ-001 SHALL have parameter CH, default 32, meaning number of independent pulse channels (1..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the filter length and per-channel counters.
REQ-003 SHALL have parameter SYNC_STG, default 2, meaning number of input synchronizer flops per channel (2..4).
REQ-004 SHALL have port clk_20m, input, 1 bit: the single 20 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port pulse_in, input, CH bits: raw asynchronous pulses.
REQ-007 SHALL have port filter_cfg, input, CNT_W bits: requested filter length N, in clocks.
REQ-008 SHALL have port mode_cfg, input, 2 bits: requested mode.
REQ-009 SHALL have port cfg_load, input, 1 bit: single-cycle strobe that applies filter_cfg and mode_cfg.
REQ-010 SHALL have port glitch_clr, input, 1 bit: clears glitch_cnt.
REQ-011 SHALL have port pulse_out, output, CH bits: filtered level.
REQ-012 SHALL have port rise_stb, output, CH bits: one-cycle strobe on each pulse_out 0->1 transition.
REQ-013 SHALL have port glitch_cnt, output, 16 bits: saturating count of rejected glitches.

Function
REQ-014 Each pulse_in bit SHALL pass through SYNC_STG flops, reset to 0; the last stage is the sample s.
REQ-015 Active N and mode SHALL be shadow registers, loaded on the cycle cfg_load=1; filter_cfg and mode_cfg are ignored otherwise.
REQ-016 Active N=0 SHALL behave as N=1.
REQ-017 Mode 00 (bypass): pulse_out SHALL equal s delayed one clock; counters are held at 0.
REQ-018 Mode 01 (symmetric): pulse_out SHALL change only after s has differed from pulse_out for N consecutive samples.
REQ-019 Mode 10 (rise-only): rising transitions SHALL be qualified as in mode 01; s=0 SHALL clear pulse_out on the next clock.
REQ-020 Mode 11 SHALL behave as mode 01.
REQ-021 Each channel SHALL have a two-state FSM: STABLE while s==pulse_out, with cnt=0; QUALIFY while s!=pulse_out, with cnt incrementing each cycle.
REQ-022 In QUALIFY, when s!=pulse_out and cnt==N-1, pulse_out SHALL toggle at that clock edge, cnt SHALL go to 0 and the FSM SHALL return to STABLE.
REQ-023 In QUALIFY, when s returns equal to pulse_out before qualification, the FSM SHALL return to STABLE, cnt SHALL go to 0 and the event is a glitch.
REQ-024 Latency from a clean pulse_in edge to pulse_out SHALL be SYNC_STG+N clocks in modes 01, 10 and 11, and SYNC_STG+1 clocks in mode 00.
REQ-025 cnt SHALL never wrap; the compare at N-1 bounds it for any N up to 2^CNT_W-1.
REQ-026 rise_stb[i] SHALL be 1 for exactly the cycle after pulse_out[i] goes 0->1 (registered edge detect).
REQ-027 glitch_cnt SHALL increment by 1 in each cycle where at least one channel records a glitch, and SHALL saturate at 0xFFFF.
REQ-028 glitch_clr SHALL have priority over a same-cycle increment; the result is 0.
REQ-029 A cfg_load SHALL reset all channel counters to 0 and all FSMs to STABLE in the same cycle; pulse_out SHALL be held, and no glitch is counted.

Reset
REQ-030 While rst=1, all synchronizers, pulse_out, rise_stb, cnt and glitch_cnt SHALL be 0 and all FSMs SHALL be STABLE.
REQ-031 While rst=1, active N SHALL be 1 and active mode SHALL be 01.
REQ-032 Reset assertion mid-qualification SHALL take effect immediately (asynchronously); the first qualification after release starts from cnt=0.

Verification
REQ-033 Scenario: SYNC_STG=2, load N=5 mode 01, pulse_in[3] 0->1 held -> pulse_out[3] rises 7 clocks later, rise_stb[3] high for 1 clock, glitch_cnt=0.
REQ-034 Scenario: N=5 mode 01, 4-clock high pulse on pulse_in[0] -> pulse_out stays 0 and glitch_cnt=1; repeat on ch0 and ch7 in the same cycle -> glitch_cnt=2.
REQ-035 Scenario: mode 10, N=100, pulse_out[1]=1, pulse_in[1] falls -> pulse_out[1]=0 after 3 clocks; mode 00 -> all bits follow with 3-clock delay.
REQ-036 Scenario: glitch_cnt preloaded to 0xFFFF via 65535 glitches, then one more glitch -> stays 0xFFFF; glitch_clr with a coincident glitch -> 0.
REQ-037 Scenario: N=10 mode 01, cfg_load (N=3) at cnt=6 -> cnt=0 and pulse_out unchanged; the channel qualifies 3 clocks later if the input is still different.
REQ-038 Scenario: rst asserted while cnt=8 of N=10 -> outputs 0 without a clock edge; after release, defaults N=1 mode 01 apply.
